// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU.
//   - Opcode encodings presented on the 3-bit op input.
//   - Control FSM state encoding used by iter_alu.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_MULH = 3'd3;
    localparam logic [2:0] OP_MULL = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_REM  = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/iter_muldiv_core.sv
// Unsigned magnitude datapath: shift-add multiply or restoring divide,
// WIDTH iterations per operation.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   start       load x/y and begin iterating (ignored mode bits while busy)
//   div_mode    0 = multiply x*y, 1 = divide x/y (captured on start)
//   x, y        unsigned operands (multiplier/multiplicand or dividend/divisor)
//   done        high during the final iteration; results valid the cycle after
//   product     2*WIDTH-bit unsigned product
//   quotient    WIDTH-bit unsigned quotient
//   remainder   WIDTH-bit unsigned remainder
module iter_muldiv_core #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // hi/lo form one double-width shift register: product {hi,lo} when
    // multiplying, {remainder,quotient} when dividing.
    logic [WIDTH-1:0] hi, lo, m;
    logic [CNT_W-1:0] cnt;
    logic             busy, mode;

    logic [WIDTH:0]   add_sum, shl, trial;

    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        shl     = {hi, lo[WIDTH-1]};
        trial   = shl - {1'b0, m};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            m    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            mode <= 1'b0;
        end else if (start) begin
            hi   <= '0;
            lo   <= x;
            m    <= y;
            cnt  <= '0;
            busy <= 1'b1;
            mode <= div_mode;
        end else if (busy) begin
            if (mode) begin
                // Restoring step: keep the subtraction only when it did not borrow.
                if (!trial[WIDTH]) begin
                    hi <= trial[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= shl[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                // Add-then-shift-right; the adder carry enters hi's MSB.
                hi <= add_sum[WIDTH:1];
                lo <= {add_sum[0], lo[WIDTH-1:1]};
            end
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign done      = busy && (cnt == LAST);
    assign product   = {hi, lo};
    assign quotient  = lo;
    assign remainder = hi;

endmodule

// File: rtl/iter_alu.sv
// Handshaked signed ALU with iterative multiply/divide.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    request handshake; in_ready is high only in IDLE
//   op, a, b             opcode (alu_pkg OP_*) and signed operands
//   out_valid/out_ready  result handshake; res/ovf/div0 held until accepted
//   res                  signed result
//   ovf                  signed overflow (ADD/SUB/MULL, DIV of MIN by -1)
//   div0                 DIV/REM attempted with b == 0
// Handshake: a transfer happens on a rising edge where valid && ready;
// the producer holds its payload stable until then.
module iter_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             ovf,
    output logic             div0
);

    state_t           state, state_next;
    logic [2:0]       op_r;
    logic             sign_a, sign_b;

    logic             load;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next, div0_next;

    logic             core_start, core_div, core_done;
    logic [2*WIDTH-1:0] product, prod_s;
    logic [WIDTH-1:0] quotient, remainder, quot_s, rem_s;
    logic [WIDTH-1:0] mag_a, mag_b, sum, diff;

    // Magnitudes are unsigned, so |MIN| = 2^(WIDTH-1) is representable.
    assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign sum   = a + b;
    assign diff  = a - b;

    assign prod_s = (sign_a ^ sign_b) ? (~product + 1'b1) : product;
    assign quot_s = (sign_a ^ sign_b) ? (~quotient + 1'b1) : quotient;
    assign rem_s  = sign_a ? (~remainder + 1'b1) : remainder;

    iter_muldiv_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (core_start),
        .div_mode  (core_div),
        .x         (mag_a),
        .y         (mag_b),
        .done      (core_done),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        res_next   = '0;
        ovf_next   = 1'b0;
        div0_next  = 1'b0;
        core_start = 1'b0;
        core_div   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    // Every accept rewrites res and clears flags.
                    load = 1'b1;
                    case (op)
                        OP_ADD: begin
                            res_next   = sum;
                            ovf_next   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                            state_next = DONE;
                        end
                        OP_SUB: begin
                            res_next   = diff;
                            ovf_next   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                            state_next = DONE;
                        end
                        OP_AND: begin
                            res_next   = a & b;
                            state_next = DONE;
                        end
                        OP_XOR: begin
                            res_next   = a ^ b;
                            state_next = DONE;
                        end
                        OP_MULH, OP_MULL: begin
                            core_start = 1'b1;
                            state_next = MUL;
                        end
                        default: begin
                            if (b == '0) begin
                                res_next   = (op == OP_DIV) ? '1 : a;
                                div0_next  = 1'b1;
                                state_next = DONE;
                            end else begin
                                core_start = 1'b1;
                                core_div   = 1'b1;
                                state_next = DIV;
                            end
                        end
                    endcase
                end
            end
            MUL, DIV: begin
                if (core_done) state_next = FIX;
            end
            FIX: begin
                load       = 1'b1;
                state_next = DONE;
                case (op_r)
                    OP_MULH: res_next = prod_s[2*WIDTH-1:WIDTH];
                    OP_MULL: begin
                        res_next = prod_s[WIDTH-1:0];
                        ovf_next = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
                    end
                    OP_DIV: begin
                        res_next = quot_s;
                        // Only MIN / -1 yields a positive quotient with the MSB set.
                        ovf_next = !(sign_a ^ sign_b) && quotient[WIDTH-1];
                    end
                    default: res_next = rem_s;
                endcase
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_r   <= OP_ADD;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            res    <= '0;
            ovf    <= 1'b0;
            div0   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && in_valid) begin
                op_r   <= op;
                sign_a <= a[WIDTH-1];
                sign_b <= b[WIDTH-1];
            end
            if (load) begin
                res  <= res_next;
                ovf  <= ovf_next;
                div0 <= div0_next;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;
  import alu_pkg::*;

  localparam int W = 16;
  localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W - 1));

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         ovf;
  logic         div0;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];
  logic         exp_div0_q[$];

  iter_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .ovf       (ovf),
    .div0      (div0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input bit ok, input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit out_of_range(input longint v);
    return (v > MAXV) || (v < MINV);
  endfunction

  // Reference model straight from the arithmetic definitions.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic ov, output logic dz);
    longint sa, sb, full;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    r = '0; ov = 1'b0; dz = 1'b0; full = 0;
    case (o)
      OP_ADD:  begin full = sa + sb; r = full[W-1:0]; ov = out_of_range(full); end
      OP_SUB:  begin full = sa - sb; r = full[W-1:0]; ov = out_of_range(full); end
      OP_AND:  r = x & y;
      OP_XOR:  r = x ^ y;
      OP_MULH: begin full = sa * sb; full = full >>> W; r = full[W-1:0]; end
      OP_MULL: begin full = sa * sb; r = full[W-1:0]; ov = out_of_range(full); end
      OP_DIV: begin
        if (sb == 0) begin r = '1; dz = 1'b1; end
        else begin full = sa / sb; r = full[W-1:0]; ov = out_of_range(full); end
      end
      default: begin
        if (sb == 0) begin r = x; dz = 1'b1; end
        else begin full = sa % sb; r = full[W-1:0]; end
      end
    endcase
  endfunction

  function automatic int latency_of(input logic [2:0] o, input logic [W-1:0] y);
    if (o == OP_MULH || o == OP_MULL) return W + 2;
    if ((o == OP_DIV || o == OP_REM) && y != '0) return W + 2;
    return 1;
  endfunction

  // Pin the model to hand-computed values.
  task automatic pin(input string name, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] er, input logic eo, input logic ez);
    logic [W-1:0] r;
    logic ov, dz;
    model(o, x, y, r, ov, dz);
    chk(r == er, {name, "_res"}, r, er);
    chk(ov == eo, {name, "_ovf"}, W'(ov), W'(eo));
    chk(dz == ez, {name, "_div0"}, W'(dz), W'(ez));
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold, input bit intruder);
    logic [W-1:0] er;
    logic eo, ez;
    int n;
    model(o, x, y, er, eo, ez);
    op = o; a = x; b = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk(1'b0, "accept_timeout", W'(in_ready), W'(1));
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(er);
    exp_ovf_q.push_back(eo);
    exp_div0_q.push_back(ez);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk(in_ready == 1'b0, "in_ready_drop", W'(in_ready), W'(0));
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk(n == latency_of(o, y), "latency", W'(n), W'(latency_of(o, y)));
    if (!out_valid) begin
      exp_q.delete(); exp_ovf_q.delete(); exp_div0_q.delete();
      return;
    end
    if (intruder) begin
      op = OP_ADD; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    end
    repeat (hold) begin
      @(posedge clk); #1;
      if (intruder) chk(in_ready == 1'b0, "busy_in_ready", W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(out_valid == 1'b0, "out_valid_drop", W'(out_valid), W'(0));
    if (intruder) begin
      repeat (3) @(posedge clk);
      #1;
      chk(out_valid == 1'b0, "intruder_ignored", W'(out_valid), W'(0));
    end
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return W'(16'h8000);
      4: return W'(16'h7FFF);
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_out_valid", res, '0);
      end else begin
        chk(res == exp_q[0], "res", res, exp_q[0]);
        chk(ovf == exp_ovf_q[0], "ovf", W'(ovf), W'(exp_ovf_q[0]));
        chk(div0 == exp_div0_q[0], "div0", W'(div0), W'(exp_div0_q[0]));
        chk(in_ready == 1'b0, "in_ready_while_out", W'(in_ready), W'(0));
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_ovf_q.pop_front());
          void'(exp_div0_q.pop_front());
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = OP_ADD; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "rst_out_valid", W'(out_valid), W'(0));
    chk(res == '0, "rst_res", res, '0);
    chk(ovf == 1'b0, "rst_ovf", W'(ovf), W'(0));
    chk(div0 == 1'b0, "rst_div0", W'(div0), W'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk(in_ready == 1'b1, "rst_in_ready", W'(in_ready), W'(1));

    pin("m_add",   OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0);
    pin("m_sub",   OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    pin("m_mull",  OP_MULL, 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 1'b0);
    pin("m_mulh",  OP_MULH, 16'h4000, 16'h0004, 16'h0001, 1'b0, 1'b0);
    pin("m_mullo", OP_MULL, 16'h4000, 16'h0004, 16'h0000, 1'b1, 1'b0);
    pin("m_div",   OP_DIV,  16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 1'b0);
    pin("m_rem",   OP_REM,  16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 1'b0);
    pin("m_divmn", OP_DIV,  16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0);
    pin("m_remmn", OP_REM,  16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    pin("m_div0",  OP_DIV,  16'h0005, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    pin("m_rem0",  OP_REM,  16'h0005, 16'h0000, 16'h0005, 1'b0, 1'b1);

    run_op(OP_ADD,  16'h7FFF, 16'h0001, 0, 1'b0);
    run_op(OP_SUB,  16'h0005, 16'h0007, 0, 1'b0);
    run_op(OP_MULL, 16'hFFFD, 16'h0007, 0, 1'b0);
    run_op(OP_MULH, 16'h4000, 16'h0004, 0, 1'b0);
    run_op(OP_MULL, 16'h4000, 16'h0004, 0, 1'b0);
    run_op(OP_DIV,  16'hFFF9, 16'h0002, 0, 1'b0);
    run_op(OP_REM,  16'hFFF9, 16'h0002, 0, 1'b0);
    run_op(OP_DIV,  16'h8000, 16'hFFFF, 0, 1'b0);
    run_op(OP_REM,  16'h8000, 16'hFFFF, 0, 1'b0);
    run_op(OP_DIV,  16'h0005, 16'h0000, 0, 1'b0);
    run_op(OP_REM,  16'h0005, 16'h0000, 0, 1'b0);
    run_op(OP_AND,  16'hF0F0, 16'h3C3C, 0, 1'b0);
    run_op(OP_XOR,  16'hF0F0, 16'h3C3C, 0, 1'b0);
    // Backpressure with a competing request held during the stall.
    run_op(OP_MULL, 16'h0003, 16'h0005, 5, 1'b1);
    run_op(OP_ADD,  16'h0002, 16'h0003, 5, 1'b1);

    // Reset in the middle of a divide.
    op = OP_DIV; a = 16'h1234; b = 16'h0035; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "mid_div_busy", W'(out_valid), W'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete(); exp_ovf_q.delete(); exp_div0_q.delete();
    chk(out_valid == 1'b0, "abort_out_valid", W'(out_valid), W'(0));
    chk(in_ready == 1'b1, "abort_in_ready", W'(in_ready), W'(1));
    chk(res == '0, "abort_res", res, '0);
    pin("m_add11", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
    run_op(OP_ADD, 16'h0001, 16'h0001, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), $urandom_range(0, 3), 1'b0);
    end

    repeat (2) @(posedge clk);
    chk(exp_q.size() == 0, "queue_drained", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
